// File: rtl/bp_fe_instr_gen.sv
// bp_fe_instr_gen
// Control-flow instruction encoder for the front end (inverse of the FE scan
// decoder). A scan-class command (branch / jalr / jal / default) with a
// sign-extended byte offset and register fields is packed into a 32-bit RV64
// instruction word and queued in a 2-entry FIFO. Immediates that cannot be
// encoded (out of range or misaligned) are replaced by a NOP flagged with
// err_o, and counted in a saturating error counter.
//
// Ports:
//   clk_i, reset_i        : clock, asynchronous active-high reset
//   v_i / ready_o         : command handshake (accept on v_i & ready_o)
//   class_i               : scan class (branch=0, jalr=1, jal=2, default=3)
//   imm_i                 : sign-extended byte offset
//   rs1_i, rs2_i, rd_i    : register fields
//   funct3_i              : branch condition (encoded verbatim)
//   v_o / yumi_i          : FIFO head valid / consumer takes head
//   instr_o, err_o        : head instruction and its encode-error flag
//   err_cnt_o             : saturating count of encode errors
module bp_fe_instr_gen #(
    parameter int instr_width_p   = 32,
    parameter int imm_width_p     = 64,
    parameter int err_cnt_width_p = 8
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       v_i,
    output logic                       ready_o,
    input  logic [1:0]                 class_i,
    input  logic [imm_width_p-1:0]     imm_i,
    input  logic [4:0]                 rs1_i,
    input  logic [4:0]                 rs2_i,
    input  logic [4:0]                 rd_i,
    input  logic [2:0]                 funct3_i,
    output logic                       v_o,
    output logic [instr_width_p-1:0]   instr_o,
    output logic                       err_o,
    input  logic                       yumi_i,
    output logic [err_cnt_width_p-1:0] err_cnt_o
);

    localparam logic [1:0] e_rvi_branch = 2'd0;
    localparam logic [1:0] e_rvi_jalr   = 2'd1;
    localparam logic [1:0] e_rvi_jal    = 2'd2;
    localparam logic [1:0] e_default    = 2'd3;

    localparam logic [instr_width_p-1:0] nop_instr = 32'h0000_0013;
    localparam logic [6:0] op_branch = 7'b1100011;
    localparam logic [6:0] op_jalr   = 7'b1100111;
    localparam logic [6:0] op_jal    = 7'b1101111;

    localparam logic [err_cnt_width_p-1:0] err_cnt_max = {err_cnt_width_p{1'b1}};
    localparam logic [err_cnt_width_p-1:0] err_cnt_one = {{(err_cnt_width_p-1){1'b0}}, 1'b1};

    // True when imm is representable as an nbits-wide two's complement value:
    // everything from bit nbits-1 upward must be a copy of the sign.
    function automatic logic fits_signed(input logic [imm_width_p-1:0] imm, input int nbits);
        logic signed [imm_width_p-1:0] upper;
        upper = $signed(imm) >>> (nbits - 1);
        return (upper == {imm_width_p{1'b0}}) || (upper == {imm_width_p{1'b1}});
    endfunction

    logic [instr_width_p-1:0]   enc_instr_s;
    logic                       enc_err_s;

    logic [instr_width_p-1:0]   mem_instr_r [0:1];
    logic                       mem_err_r   [0:1];
    logic [instr_width_p-1:0]   mem_instr_n_s [0:1];
    logic                       mem_err_n_s   [0:1];
    logic                       wr_ptr_r, rd_ptr_r, wr_ptr_n_s, rd_ptr_n_s;
    logic [1:0]                 count_r, count_n_s;
    logic                       ready_r, v_r, err_r;
    logic [instr_width_p-1:0]   instr_r;
    logic [err_cnt_width_p-1:0] err_cnt_r, err_cnt_n_s;
    logic                       enq_s, deq_s;

    // Encode the incoming command; unencodable immediates become a flagged NOP.
    always_comb begin
        enc_instr_s = nop_instr;
        enc_err_s   = 1'b0;
        case (class_i)
            e_rvi_branch: begin
                // 13-bit signed offset, halfword aligned (bit 0 is implicit).
                if (fits_signed(imm_i, 13) && (imm_i[0] == 1'b0)) begin
                    enc_instr_s = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                                   imm_i[4:1], imm_i[11], op_branch};
                end else begin
                    enc_err_s = 1'b1;
                end
            end
            e_rvi_jalr: begin
                // jalr adds a full 12-bit signed offset; any parity is legal.
                if (fits_signed(imm_i, 12)) begin
                    enc_instr_s = {imm_i[11:0], rs1_i, 3'b000, rd_i, op_jalr};
                end else begin
                    enc_err_s = 1'b1;
                end
            end
            e_rvi_jal: begin
                if (fits_signed(imm_i, 21) && (imm_i[0] == 1'b0)) begin
                    enc_instr_s = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12],
                                   rd_i, op_jal};
                end else begin
                    enc_err_s = 1'b1;
                end
            end
            e_default: begin
                enc_instr_s = nop_instr;
                enc_err_s   = 1'b0;
            end
            default: begin
                enc_instr_s = nop_instr;
                enc_err_s   = 1'b0;
            end
        endcase
    end

    // FIFO next-state: storage, pointers, count, head view and error counter.
    always_comb begin
        enq_s         = v_i & ready_r;
        // v_r mirrors count != 0, so a stray yumi on an empty FIFO is ignored.
        deq_s         = yumi_i & v_r;
        mem_instr_n_s = mem_instr_r;
        mem_err_n_s   = mem_err_r;
        count_n_s     = count_r;
        err_cnt_n_s   = err_cnt_r;

        if (enq_s) begin
            mem_instr_n_s[wr_ptr_r] = enc_instr_s;
            mem_err_n_s[wr_ptr_r]   = enc_err_s;
        end else begin
            mem_instr_n_s = mem_instr_r;
            mem_err_n_s   = mem_err_r;
        end

        // Single-bit pointers wrap from 1 back to 0 naturally.
        wr_ptr_n_s = wr_ptr_r ^ enq_s;
        rd_ptr_n_s = rd_ptr_r ^ deq_s;

        case ({enq_s, deq_s})
            2'b10:   count_n_s = count_r + 2'd1;
            2'b01:   count_n_s = count_r - 2'd1;
            default: count_n_s = count_r;
        endcase

        if (enq_s && enc_err_s && (err_cnt_r != err_cnt_max)) begin
            err_cnt_n_s = err_cnt_r + err_cnt_one;
        end else begin
            err_cnt_n_s = err_cnt_r;
        end
    end

    // State and registered outputs; the head is pre-selected from next state
    // so instr_o/err_o come straight from flops.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            mem_instr_r[0] <= nop_instr;
            mem_instr_r[1] <= nop_instr;
            mem_err_r[0]   <= 1'b0;
            mem_err_r[1]   <= 1'b0;
            wr_ptr_r       <= 1'b0;
            rd_ptr_r       <= 1'b0;
            count_r        <= 2'd0;
            ready_r        <= 1'b0;
            v_r            <= 1'b0;
            instr_r        <= nop_instr;
            err_r          <= 1'b0;
            err_cnt_r      <= {err_cnt_width_p{1'b0}};
        end else begin
            mem_instr_r <= mem_instr_n_s;
            mem_err_r   <= mem_err_n_s;
            wr_ptr_r    <= wr_ptr_n_s;
            rd_ptr_r    <= rd_ptr_n_s;
            count_r     <= count_n_s;
            ready_r     <= (count_n_s != 2'd2);
            v_r         <= (count_n_s != 2'd0);
            instr_r     <= mem_instr_n_s[rd_ptr_n_s];
            err_r       <= mem_err_n_s[rd_ptr_n_s];
            err_cnt_r   <= err_cnt_n_s;
        end
    end

    assign ready_o   = ready_r;
    assign v_o       = v_r;
    assign instr_o   = instr_r;
    assign err_o     = err_r;
    assign err_cnt_o = err_cnt_r;

endmodule

// File: tb/tb_bp_fe_instr_gen.sv
// Self-checking bench for bp_fe_instr_gen: a queue-based reference model
// checked every negative edge, plus hand-computed literal expectations.
module tb_bp_fe_instr_gen;

    localparam logic [1:0] CL_BR   = 2'd0;
    localparam logic [1:0] CL_JALR = 2'd1;
    localparam logic [1:0] CL_JAL  = 2'd2;
    localparam logic [1:0] CL_DEF  = 2'd3;

    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic        v_i = 1'b0;
    logic        ready_o;
    logic [1:0]  class_i = 2'd0;
    logic [63:0] imm_i = 64'd0;
    logic [4:0]  rs1_i = 5'd0, rs2_i = 5'd0, rd_i = 5'd0;
    logic [2:0]  funct3_i = 3'd0;
    logic        v_o;
    logic [31:0] instr_o;
    logic        err_o;
    logic        yumi_i = 1'b0;
    logic [7:0]  err_cnt_o;

    bp_fe_instr_gen dut (
        .clk_i(clk), .reset_i(reset_i), .v_i(v_i), .ready_o(ready_o),
        .class_i(class_i), .imm_i(imm_i), .rs1_i(rs1_i), .rs2_i(rs2_i),
        .rd_i(rd_i), .funct3_i(funct3_i), .v_o(v_o), .instr_o(instr_o),
        .err_o(err_o), .yumi_i(yumi_i), .err_cnt_o(err_cnt_o)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic        err;
        logic [31:0] instr;
    } ent_t;

    ent_t   mq[$];
    int     m_errcnt = 0;
    bit     m_rdy_ok = 1'b0;

    function automatic ent_t model_encode(input logic [1:0] cls, input longint imm,
                                          input longint rs1, input longint rs2,
                                          input longint rd, input longint f3);
        ent_t e;
        e.err   = 1'b0;
        e.instr = 32'h0000_0013;
        case (cls)
            CL_BR: begin
                if (imm < -4096 || imm > 4094 || (imm % 2) != 0) e.err = 1'b1;
                else e.instr = 32'((((imm >> 12) & 1) << 31) | (((imm >> 5) & 63) << 25) |
                                   (rs2 << 20) | (rs1 << 15) | (f3 << 12) |
                                   (((imm >> 1) & 15) << 8) | (((imm >> 11) & 1) << 7) | 99);
            end
            CL_JALR: begin
                if (imm < -2048 || imm > 2047) e.err = 1'b1;
                else e.instr = 32'(((imm & 4095) << 20) | (rs1 << 15) | (rd << 7) | 103);
            end
            CL_JAL: begin
                if (imm < -1048576 || imm > 1048574 || (imm % 2) != 0) e.err = 1'b1;
                else e.instr = 32'((((imm >> 20) & 1) << 31) | (((imm >> 1) & 1023) << 21) |
                                   (((imm >> 11) & 1) << 20) | (((imm >> 12) & 255) << 12) |
                                   (rd << 7) | 111);
            end
            default: e.instr = 32'h0000_0013;
        endcase
        return e;
    endfunction

    // Model state follows the reset/clock events of the design.
    initial begin : model_proc
        forever begin
            @(posedge clk or posedge reset_i);
            if (reset_i) begin
                mq.delete();
                m_errcnt = 0;
                m_rdy_ok = 1'b0;
            end else begin
                ent_t e;
                bit   acc;
                acc = v_i && m_rdy_ok && (mq.size() < 2);
                if (yumi_i && mq.size() > 0) void'(mq.pop_front());
                if (acc) begin
                    e = model_encode(class_i, longint'($signed(imm_i)), longint'(rs1_i),
                                     longint'(rs2_i), longint'(rd_i), longint'(funct3_i));
                    mq.push_back(e);
                    if (e.err && m_errcnt < 255) m_errcnt++;
                end
                m_rdy_ok = 1'b1;
            end
        end
    end

    // Compare DUT against the model away from the active edge.
    always @(negedge clk) begin
        chk("ready_o", 64'(ready_o), 64'(m_rdy_ok && (mq.size() < 2)));
        chk("v_o", 64'(v_o), 64'(mq.size() != 0));
        chk("err_cnt_o", 64'(err_cnt_o), 64'(m_errcnt));
        if (mq.size() != 0) begin
            chk("instr_o", 64'(instr_o), 64'(mq[0].instr));
            chk("err_o", 64'(err_o), 64'(mq[0].err));
        end
        if (yumi_i && !v_o) begin
            n_total++;
            $display("FAIL yumi_protocol: yumi_i=1 while v_o=0, expected v_o=1");
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cmd(input logic [1:0] cls, input longint imm, input int rs1,
                           input int rs2, input int rd, input int f3);
        class_i  = cls;
        imm_i    = 64'(imm);
        rs1_i    = 5'(rs1);
        rs2_i    = 5'(rs2);
        rd_i     = 5'(rd);
        funct3_i = 3'(f3);
    endtask

    task automatic send(input logic [1:0] cls, input longint imm, input int rs1,
                        input int rs2, input int rd, input int f3);
        bit r;
        int guard;
        guard = 0;
        set_cmd(cls, imm, rs1, rs2, rd, f3);
        v_i = 1'b1;
        do begin
            r = ready_o;
            step();
            guard++;
        end while (!r && guard < 50);
        if (!r) chk("send_timeout", 64'd0, 64'd1);
        v_i = 1'b0;
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (v_o && g < 10) begin
            yumi_i = 1'b1;
            step();
            g++;
        end
        yumi_i = 1'b0;
    endtask

    logic [1:0] bt_cls [10] = '{CL_BR, CL_BR, CL_BR, CL_JALR, CL_JALR, CL_JALR,
                                CL_JAL, CL_JAL, CL_JAL, CL_DEF};
    longint     bt_imm [10] = '{-4096, 4094, 5, 2047, -2048, 2048,
                                1048574, -1048576, 1048576, 12345};

    initial begin : timeout_proc
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin : stim
        step();
        chk("reset_instr", 64'(instr_o), 64'h13);
        chk("reset_err", 64'(err_o), 64'd0);
        chk("reset_v", 64'(v_o), 64'd0);
        chk("reset_ready", 64'(ready_o), 64'd0);
        step();
        reset_i = 1'b0;
        step();
        chk("ready_after_reset", 64'(ready_o), 64'd1);

        // Basic encodings
        send(CL_BR, 8, 1, 2, 0, 0);
        chk("br_v", 64'(v_o), 64'd1);
        chk("br_instr", 64'(instr_o), 64'h00208463);
        chk("br_err", 64'(err_o), 64'd0);
        drain();
        send(CL_JAL, 2048, 0, 0, 1, 0);
        chk("jal_instr", 64'(instr_o), 64'h001000EF);
        drain();
        send(CL_JALR, 0, 1, 0, 0, 0);
        chk("jalr_instr", 64'(instr_o), 64'h00008067);
        drain();

        // Encode errors
        send(CL_JAL, 3, 0, 0, 1, 0);
        chk("err1_instr", 64'(instr_o), 64'h13);
        chk("err1_err", 64'(err_o), 64'd1);
        chk("err1_cnt", 64'(err_cnt_o), 64'd1);
        drain();
        send(CL_BR, 4096, 1, 2, 0, 0);
        chk("err2_err", 64'(err_o), 64'd1);
        chk("err2_cnt", 64'(err_cnt_o), 64'd2);
        drain();

        // Range boundaries (model-checked), with two literal pins
        for (int i = 0; i < 10; i++) begin
            send(bt_cls[i], bt_imm[i], 3, 4, 5, 7);
            if (i == 0) chk("br_min_instr", 64'(instr_o), 64'h8041_F063);
            drain();
        end
        send(CL_JAL, -1048576, 0, 0, 0, 0);
        chk("jal_min_instr", 64'(instr_o), 64'h8000006F);
        drain();

        // Backpressure: three jalr commands, no yumi
        set_cmd(CL_JALR, 0, 0, 0, 0, 0); v_i = 1'b1; step();
        set_cmd(CL_JALR, 1, 0, 0, 0, 0); step();
        set_cmd(CL_JALR, 2, 0, 0, 0, 0); step(); step();
        chk("bp_full_ready", 64'(ready_o), 64'd0);
        chk("bp_head0", 64'(instr_o), 64'h00000067);
        yumi_i = 1'b1; step(); yumi_i = 1'b0;
        chk("bp_head1", 64'(instr_o), 64'h00100067);
        step();
        v_i = 1'b0;
        chk("bp_refull_ready", 64'(ready_o), 64'd0);
        yumi_i = 1'b1; step(); yumi_i = 1'b0;
        chk("bp_head2", 64'(instr_o), 64'h00200067);
        drain();
        chk("bp_empty", 64'(v_o), 64'd0);

        // Simultaneous enqueue and dequeue at count 1
        send(CL_JALR, 100, 2, 0, 3, 0);
        for (int i = 0; i < 10; i++) begin
            set_cmd(CL_JAL, longint'(i * 4 - 20), 0, 0, i + 1, 0);
            v_i = 1'b1;
            yumi_i = 1'b1;
            step();
        end
        v_i = 1'b0;
        yumi_i = 1'b0;
        chk("sim_ready", 64'(ready_o), 64'd1);
        drain();

        // Error counter saturation
        for (int i = 0; i < 300; i++) begin
            set_cmd(CL_JAL, 1, 0, 0, 0, 0);
            v_i = 1'b1;
            yumi_i = v_o;
            step();
        end
        v_i = 1'b0;
        yumi_i = 1'b0;
        drain();
        chk("sat_cnt", 64'(err_cnt_o), 64'd255);
        send(CL_BR, 3, 0, 0, 0, 0);
        drain();
        chk("sat_hold", 64'(err_cnt_o), 64'd255);

        // Asynchronous reset with two entries held
        send(CL_JALR, 4, 0, 0, 0, 0);
        send(CL_JALR, 8, 0, 0, 0, 0);
        #3;
        reset_i = 1'b1;
        #1;
        chk("rst_v", 64'(v_o), 64'd0);
        chk("rst_cnt", 64'(err_cnt_o), 64'd0);
        chk("rst_ready", 64'(ready_o), 64'd0);
        step();
        chk("rst_instr", 64'(instr_o), 64'h13);
        chk("rst_err", 64'(err_o), 64'd0);
        #3;
        reset_i = 1'b0;
        step();
        chk("post_rst_ready", 64'(ready_o), 64'd1);
        chk("post_rst_v", 64'(v_o), 64'd0);
        send(CL_JAL, 8, 0, 0, 1, 0);
        chk("post_rst_instr", 64'(instr_o), 64'h008000EF);
        yumi_i = 1'b1; step(); yumi_i = 1'b0;
        chk("post_rst_alone", 64'(v_o), 64'd0);
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
